// File: rtl/fp_unit_seq.sv
// Responder side of the fpUnit handshake: latches one FP request, runs the shared
// pipelined cores for the op's fixed latency, captures the core output and pulses fp_done.
// Optional feature macro: FPU_ILLEGAL_OP_EN (ops 6/7 flagged as illegal instead of aliased).
module fp_unit_seq #(
    parameter int LAT_ADDSUB = 7,
    parameter int LAT_MUL    = 5,
    parameter int LAT_DIV    = 6,
    parameter int LAT_CONV   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fp_dataa,
    input  logic [31:0] fp_datab,
    input  logic [2:0]  fp_operation,
    input  logic        fp_clk_en,
    output logic        fp_done,
    output logic [31:0] fp_result,
    output logic        fp_err,
    output logic [31:0] core_dataa,
    output logic [31:0] core_datab,
    output logic        core_add_sub,
    output logic        core_clk_en,
    input  logic [31:0] addsub_result,
    input  logic [31:0] mul_result,
    input  logic [31:0] div_result,
    input  logic [31:0] fixsi_result,
    input  logic [31:0] floatis_result
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CAPTURE,
        DONE,
        WAIT_REL
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_dataa;
    logic [31:0] r_datab;
    logic        r_add_sub;
    logic        r_core_clk_en;
    logic        r_done;
    logic [31:0] r_result;

    logic [2:0]  w_op_eff;
    logic        w_illegal;
    logic [3:0]  w_lat;
    logic [31:0] w_core_sel;

    // Opcode decode at acceptance; ops 6/7 either alias onto div/mul or are flagged.
    always_comb begin
        w_op_eff  = fp_operation;
        w_illegal = 1'b0;
`ifdef FPU_ILLEGAL_OP_EN
        w_illegal = (fp_operation[2:1] == 2'b11);
`else
        if (fp_operation[2:1] == 2'b11) begin
            w_op_eff = {1'b0, fp_operation[1:0]};
        end
`endif
    end

    always_comb begin
        w_lat = 4'(LAT_CONV);
        case (w_op_eff)
            3'd0, 3'd1: w_lat = 4'(LAT_ADDSUB);
            3'd2:       w_lat = 4'(LAT_DIV);
            3'd3:       w_lat = 4'(LAT_MUL);
            default:    w_lat = 4'(LAT_CONV);
        endcase
    end

    always_comb begin
        w_core_sel = 32'h0;
        case (r_op)
            3'd0, 3'd1: w_core_sel = addsub_result;
            3'd2:       w_core_sel = div_result;
            3'd3:       w_core_sel = mul_result;
            3'd4:       w_core_sel = fixsi_result;
            3'd5:       w_core_sel = floatis_result;
            default:    w_core_sel = 32'h0;
        endcase
    end

    // fp_done is registered on the DONE->WAIT_REL edge, giving LAT+2 request-to-done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_op          <= 3'd0;
            r_dataa       <= 32'h0;
            r_datab       <= 32'h0;
            r_add_sub     <= 1'b0;
            r_core_clk_en <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= 32'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fp_clk_en) begin
                        r_dataa   <= fp_dataa;
                        r_datab   <= fp_datab;
                        r_op      <= w_op_eff;
                        r_add_sub <= (w_op_eff == 3'd1);
                        if (w_illegal) begin
                            r_cnt   <= 4'd0;
                            r_state <= CAPTURE;
                        end else begin
                            r_cnt         <= w_lat;
                            r_core_clk_en <= 1'b1;
                            r_state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!fp_clk_en) begin
                        r_core_clk_en <= 1'b0;
                        r_cnt         <= 4'd0;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_core_clk_en <= 1'b0;
                            r_state       <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (!fp_clk_en) begin
                        r_state <= IDLE;
                    end else begin
                        r_result <= w_core_sel;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!fp_clk_en) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FPU_ILLEGAL_OP_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == CAPTURE && fp_clk_en && r_op[2:1] == 2'b11) begin
            r_err <= 1'b1;
        end
    end

    assign fp_err = r_err;
`else
    assign fp_err = 1'b0;
`endif

    assign fp_done      = r_done;
    assign fp_result    = r_result;
    assign core_dataa   = r_dataa;
    assign core_datab   = r_datab;
    assign core_add_sub = r_add_sub;
    assign core_clk_en  = r_core_clk_en;

endmodule
